// File: rtl/frog_log_rider.sv
// Frog position controller: hops, log riding, drowning, death timer, lives.
// Define FROG_HOP_LATCH_EN to buffer one hop requested during cooldown.
module frog_log_rider #(
  parameter int FROG_START_X = 320,
  parameter int FROG_START_Y = 448,
  parameter int FROG_MIN_Y   = 32,
  parameter int HOP_STEP     = 32,
  parameter int PLAY_X_MIN   = 207,
  parameter int PLAY_X_MAX   = 431,
  parameter int RIVER_TOP    = 64,
  parameter int RIVER_BOT    = 224,
  parameter int LOG_HALF_W   = 64,
  parameter int HOP_COOLDOWN = 500000,
  parameter int DEATH_TIME   = 3000000,
  parameter int LIVES        = 3
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       hop_up,
  input  logic       hop_down,
  input  logic       hop_left,
  input  logic       hop_right,
  input  logic [9:0] logX,
  input  logic [9:0] logY,
  input  logic       log_moved,
  output logic [9:0] frogX,
  output logic [9:0] frogY,
  output logic       on_log,
  output logic       died,
  output logic       dead,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam int CMAX = (DEATH_TIME > HOP_COOLDOWN) ?
                        DEATH_TIME : HOP_COOLDOWN;
  localparam int CW = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] HOP_LD = CW'(HOP_COOLDOWN - 1);
  localparam logic [CW-1:0] DTH_LD = CW'(DEATH_TIME - 1);
  localparam logic [9:0]  SX10   = 10'(FROG_START_X);
  localparam logic [9:0]  SY10   = 10'(FROG_START_Y);
  localparam logic [9:0]  TOP10  = 10'(RIVER_TOP);
  localparam logic [9:0]  BOT10  = 10'(RIVER_BOT);
  localparam logic [9:0]  XMAX10 = 10'(PLAY_X_MAX);
  localparam logic [10:0] STEP11 = 11'(HOP_STEP);
  localparam logic [10:0] MINY11 = 11'(FROG_MIN_Y);
  localparam logic [10:0] MAXY11 = 11'(FROG_START_Y);
  localparam logic [10:0] XMIN11 = 11'(PLAY_X_MIN);
  localparam logic [10:0] XMAX11 = 11'(PLAY_X_MAX);
  localparam logic [10:0] HALF11 = 11'(LOG_HALF_W);

  typedef enum logic [1:0] {LAND, RIDING, DEAD, OVER} state_t;

  state_t        state;
  logic [CW-1:0] cool;
  logic [CW-1:0] dcnt;
  logic [9:0]    log_x_q;
  logic [9:0]    log_y_q;

  logic [3:0]  req, eff, sel;
  logic [10:0] up_y, dn_y, lf_x, rt_x, dx;
  logic [9:0]  up_y10, dn_y10, lf_x10, rt_x10;
  logic        alive, in_band, overlap;
  logic        eval_die, carry_die, hop_go;

`ifdef FROG_HOP_LATCH_EN
  logic [3:0] hbuf;
  logic [3:0] req_top;
`endif

  // One-hot of the highest-priority request (up > down > left > right)
  function automatic logic [3:0] first(input logic [3:0] r);
    if (r[3])      return 4'b1000;
    else if (r[2]) return 4'b0100;
    else if (r[1]) return 4'b0010;
    else if (r[0]) return 4'b0001;
    else           return 4'b0000;
  endfunction

  always_comb begin
    req = {hop_up, hop_down, hop_left, hop_right};
`ifdef FROG_HOP_LATCH_EN
    req_top = first(req);
    eff = (cool == '0) ? (req | hbuf) : 4'b0000;
`else
    eff = (cool == '0) ? req : 4'b0000;
`endif
    sel = first(eff);

    up_y = {1'b0, frogY} - STEP11;
    if (up_y[10] || up_y < MINY11) up_y = MINY11;
    dn_y = {1'b0, frogY} + STEP11;
    if (dn_y > MAXY11) dn_y = MAXY11;
    lf_x = {1'b0, frogX} - STEP11;
    if (lf_x[10] || lf_x < XMIN11) lf_x = XMIN11;
    rt_x = {1'b0, frogX} + STEP11;
    if (rt_x > XMAX11) rt_x = XMAX11;
    up_y10 = up_y[9:0];
    dn_y10 = dn_y[9:0];
    lf_x10 = lf_x[9:0];
    rt_x10 = rt_x[9:0];

    dx = (frogX >= log_x_q) ? {1'b0, frogX - log_x_q}
                            : {1'b0, log_x_q - frogX};
    overlap = (frogY == log_y_q) && (dx <= HALF11);
    in_band = (frogY >= TOP10) && (frogY <= BOT10);
    alive = (state == LAND) || (state == RIDING);

    eval_die  = alive && in_band && !overlap;
    hop_go    = alive && !eval_die && (sel != 4'b0000);
    carry_die = (state == RIDING) && log_moved && !hop_go &&
                !eval_die && (frogX >= XMAX10);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state     <= LAND;
      frogX     <= SX10;
      frogY     <= SY10;
      cool      <= '0;
      dcnt      <= '0;
      log_x_q   <= '0;
      log_y_q   <= '0;
      on_log    <= 1'b0;
      died      <= 1'b0;
      dead      <= 1'b0;
      game_over <= 1'b0;
      lives     <= 2'(LIVES);
    end else begin
      died    <= 1'b0;
      log_x_q <= logX;
      log_y_q <= logY;
      unique case (state)
        LAND, RIDING: begin
          if (cool != '0) cool <= cool - 1'b1;
          if (eval_die || carry_die) begin
            state  <= DEAD;
            died   <= 1'b1;
            dead   <= 1'b1;
            on_log <= 1'b0;
            dcnt   <= DTH_LD;
            if (lives != 2'd0) lives <= lives - 2'd1;
          end else begin
            state  <= in_band ? RIDING : LAND;
            on_log <= in_band;
            if (hop_go) begin
              cool <= HOP_LD;
              unique case (1'b1)
                sel[3]: frogY <= up_y10;
                sel[2]: frogY <= dn_y10;
                sel[1]: frogX <= lf_x10;
                sel[0]: frogX <= rt_x10;
              endcase
            end else if (state == RIDING && log_moved) begin
              frogX <= frogX + 10'd1;
            end
          end
        end
        DEAD: begin
          if (dcnt != '0) begin
            dcnt <= dcnt - 1'b1;
          end else if (lives != 2'd0) begin
            state <= LAND;
            frogX <= SX10;
            frogY <= SY10;
            cool  <= '0;
            dead  <= 1'b0;
          end else begin
            state     <= OVER;
            game_over <= 1'b1;
          end
        end
        OVER: begin
        end
      endcase
    end
  end

`ifdef FROG_HOP_LATCH_EN
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      hbuf <= 4'b0000;
    end else if (eval_die || carry_die || hop_go) begin
      hbuf <= 4'b0000;
    end else if (alive && cool != '0 && req_top > hbuf) begin
      hbuf <= req_top;
    end
  end
`endif

endmodule

// File: tb/tb_frog_log_rider.sv
// Scoreboard bench for frog_log_rider (HOP_COOLDOWN=4, DEATH_TIME=8).
module tb_frog_log_rider;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       hop_up, hop_down, hop_left, hop_right;
  logic [9:0] logX, logY;
  logic       log_moved;
  logic [9:0] frogX, frogY;
  logic       on_log, died, dead, game_over;
  logic [1:0] lives;

  frog_log_rider #(
    .HOP_COOLDOWN(4),
    .DEATH_TIME(8)
  ) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .hop_up(hop_up),
    .hop_down(hop_down),
    .hop_left(hop_left),
    .hop_right(hop_right),
    .logX(logX),
    .logY(logY),
    .log_moved(log_moved),
    .frogX(frogX),
    .frogY(frogY),
    .on_log(on_log),
    .died(died),
    .dead(dead),
    .lives(lives),
    .game_over(game_over)
  );

  always #5 frame_clk = ~frame_clk;

  typedef enum int {FX, FY, ONL, DIED, DEADS, LIV, GO} sig_t;
  typedef struct {
    string tag;
    sig_t  sel;
    int    val;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  function automatic int peek(input sig_t s);
    case (s)
      FX:      return int'(frogX);
      FY:      return int'(frogY);
      ONL:     return int'(on_log);
      DIED:    return int'(died);
      DEADS:   return int'(dead);
      LIV:     return int'(lives);
      default: return int'(game_over);
    endcase
  endfunction

  task automatic push(input string tag, input sig_t s, input int v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, peek(e.sel), e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic clr_in();
    {hop_up, hop_down, hop_left, hop_right} = 4'b0000;
    log_moved = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
  endtask

  // d: 0 up, 1 down, 2 left, 3 right; leaves cooldown expired
  task automatic hop(input int d);
    case (d)
      0:       hop_up    = 1'b1;
      1:       hop_down  = 1'b1;
      2:       hop_left  = 1'b1;
      default: hop_right = 1'b1;
    endcase
    step(1);
    clr_in();
    step(3);
  endtask

  // Hops from the start up to y=160 keeping a log under the frog
  task automatic climb();
    for (int y = 416; y >= 160; y -= 32) begin
      logX = 10'd320;
      logY = 10'(y);
      hop(0);
    end
  endtask

  // Seven hops up with no log: frog lands at y=224 and drowns
  task automatic drown();
    logX = 10'd0;
    logY = 10'd0;
    for (int i = 0; i < 7; i++) hop(0);
  endtask

  initial begin
    Reset = 1'b1;
    clr_in();
    logX = 10'd0;
    logY = 10'd0;
    step(2);
    push("rst_x", FX, 320);
    push("rst_y", FY, 448);
    push("rst_lives", LIV, 3);
    push("rst_dead", DEADS, 0);
    push("rst_onlog", ONL, 0);
    push("rst_go", GO, 0);
    drain();
    Reset = 1'b0;

    // up beats left
    hop_up = 1'b1;
    hop_left = 1'b1;
    step(1);
    clr_in();
    push("prio_y", FY, 416);
    push("prio_x", FX, 320);
    drain();

    // down at the bottom clamps, then held up hops every 4 cycles
    do_reset();
    hop(1);
    push("down_clamp", FY, 448);
    drain();
    hop_up = 1'b1;
    step(10);
    clr_in();
    push("held_up", FY, 352);
    drain();

    // ride and carry
    do_reset();
    climb();
    logX = 10'd300;
    step(2);
    push("ride_on", ONL, 1);
    push("ride_y", FY, 160);
    push("ride_x", FX, 320);
    drain();
    for (int i = 0; i < 5; i++) begin
      log_moved = 1'b1;
      step(1);
      log_moved = 1'b0;
      step(1);
    end
    push("carry5", FX, 325);
    drain();
    hop_right = 1'b1;
    log_moved = 1'b1;
    step(1);
    clr_in();
    step(1);
    push("hop_vs_carry", FX, 357);
    push("still_on", ONL, 1);
    drain();

    // off the log: drown, timer, respawn
    do_reset();
    climb();
    logX = 10'd400;
    step(2);
    push("miss_died", DIED, 1);
    push("miss_lives", LIV, 2);
    push("miss_dead", DEADS, 1);
    push("miss_onlog", ONL, 0);
    drain();
    step(7);
    push("dead_hold", DEADS, 1);
    push("died_once", DIED, 0);
    drain();
    step(1);
    push("respawn_dead", DEADS, 0);
    push("respawn_x", FX, 320);
    push("respawn_y", FY, 448);
    drain();

    // carried past the right limit
    do_reset();
    climb();
    for (int x = 352; x <= 448; x += 32) begin
      logX = (x > 431) ? 10'd431 : 10'(x);
      hop(3);
    end
    push("edge_x", FX, 431);
    push("edge_on", ONL, 1);
    drain();
    log_moved = 1'b1;
    step(1);
    log_moved = 1'b0;
    push("edge_died", DIED, 1);
    push("edge_hold", FX, 431);
    drain();

    // reset while dead
    do_reset();
    drown();
    push("mid_dead", DEADS, 1);
    drain();
    Reset = 1'b1;
    step(1);
    push("mid_rst_x", FX, 320);
    push("mid_rst_y", FY, 448);
    push("mid_rst_lives", LIV, 3);
    push("mid_rst_dead", DEADS, 0);
    push("mid_rst_on", ONL, 0);
    drain();
    Reset = 1'b0;

    // three deaths end the game
    for (int k = 0; k < 3; k++) begin
      drown();
      push("lives_dec", LIV, 2 - k);
      drain();
      step(8);
    end
    push("over_go", GO, 1);
    push("over_lives", LIV, 0);
    push("over_dead", DEADS, 1);
    drain();
    {hop_up, hop_down, hop_left, hop_right} = 4'b1111;
    step(8);
    clr_in();
    push("over_y", FY, 224);
    push("over_x", FX, 320);
    push("over_hold", GO, 1);
    drain();
    do_reset();
    push("go_clear", GO, 0);
    push("go_lives", LIV, 3);
    drain();

    // hop requested mid-cooldown
    do_reset();
    hop_up = 1'b1;
    step(1);
    clr_in();
    step(1);
    hop_right = 1'b1;
    step(1);
    clr_in();
    step(2);
    push("latch_y", FY, 416);
`ifdef FROG_HOP_LATCH_EN
    push("latch_x", FX, 352);
`else
    push("latch_x", FX, 320);
`endif
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frog_log_rider.md
Name: frog_log_rider

Overview:
- Frog position controller that sits directly downstream of the per-lane log movers.
- Consumes one log's X/Y position and its one-cycle "moved" pulse.
- Applies player hop requests and carries the frog along with the log while the frog rides it.
- Detects drowning and swept-off-screen deaths, and manages the death timer, respawn and lives.

Parameters:
- FROG_START_X, 320, respawn X position.
- FROG_START_Y, 448, respawn Y position; also the lowest allowed Y.
- FROG_MIN_Y, 32, highest allowed Y (smallest value).
- HOP_STEP, 32, pixels moved per hop.
- PLAY_X_MIN, 207, left X clamp.
- PLAY_X_MAX, 431, right X limit; a carried frog beyond this dies.
- RIVER_TOP, 64, inclusive top Y of the river band.
- RIVER_BOT, 224, inclusive bottom Y of the river band.
- LOG_HALF_W, 64, log half-width used for the overlap test.
- HOP_COOLDOWN, 500000, cycles between accepted hops.
- DEATH_TIME, 3000000, cycles the frog stays dead before respawn.
- LIVES, 3, starting lives (1..3).

Ports:
- frame_clk  in  1  clock
- Reset  in  1  asynchronous active-high reset
- hop_up, hop_down, hop_left, hop_right  in  1 each  level hop requests
- logX, logY  in  10 each  log centre position from the log mover
- log_moved  in  1  one-cycle pulse; log advanced +1 in X this cycle
- frogX, frogY  out  10 each  registered frog position
- on_log  out  1  high while state is RIDING
- died  out  1  one-cycle pulse on entry to DEAD
- dead  out  1  high while state is DEAD or OVER
- lives  out  2  remaining lives
- game_over  out  1  high in OVER

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - frogX = FROG_START_X, frogY = FROG_START_Y.
  - State LAND; cooldown counter = 0; death counter = 0.
  - on_log = 0, died = 0, dead = 0, game_over = 0, lives = LIVES.
  - Reset mid-operation in any state returns to these values immediately.
- States: LAND, RIDING, DEAD, OVER.
- Hop acceptance:
  - Accepted only in LAND or RIDING, and only when the cooldown counter == 0.
  - Priority when several requests are high: up > down > left > right.
  - Accepting a hop loads cooldown with HOP_COOLDOWN-1; the counter then decrements to 0, one per cycle.
  - Requests made while cooldown != 0 are dropped (see optional feature).
- Hop arithmetic:
  - up: frogY -= HOP_STEP, but not below FROG_MIN_Y.
  - down: frogY += HOP_STEP, but not above FROG_START_Y.
  - left/right: frogX ∓ HOP_STEP, clamped to [PLAY_X_MIN, PLAY_X_MAX].
  - All arithmetic is done 11-bit to avoid underflow, then clamped to 10 bits.
- Overlap: frogY == logY and |frogX - logX| <= LOG_HALF_W, evaluated on registered values.
- Every cycle in LAND or RIDING, using registered frog and log values (one-cycle latency):
  - frogY inside [RIVER_TOP, RIVER_BOT] with overlap -> RIDING.
  - frogY inside the band without overlap -> DEAD.
  - frogY outside the band -> LAND.
- Carry:
  - In RIDING, log_moved = 1 -> frogX += 1.
  - If the result would exceed PLAY_X_MAX -> DEAD; frogX holds.
  - The frog does not follow the log's wrap-around.
- Hop and log_moved in the same cycle: the hop wins and the carry for that cycle is discarded.
- Entering DEAD:
  - died pulses for one cycle.
  - lives decrements, saturating at 0.
  - Death counter loads DEATH_TIME-1.
  - Position is frozen and hops are ignored.
- DEAD:
  - When the death counter reaches 0: if lives != 0, respawn to the start position in LAND with cooldown = 0.
  - Otherwise go to OVER.
- OVER: absorbing state; outputs held; only Reset exits.

Optional Feature:
- Macro: FROG_HOP_LATCH_EN.
- Defined:
  - A one-deep hop buffer captures the highest-priority request seen while cooldown != 0.
  - Later requests overwrite it only if they have higher priority.
  - The buffered hop executes in the cycle cooldown reaches 0, then the buffer clears.
  - The buffer is cleared on entry to DEAD and on Reset.
- Undefined: requests during cooldown are dropped and no buffer logic exists.

Test Plan:
Bench parameters: HOP_COOLDOWN=4, DEATH_TIME=8.
- Reset -> frogX=320, frogY=448, lives=3, dead=0, on_log=0; assert Reset mid-DEAD -> same values on the next sample.
- hop_up and hop_left held together for 1 cycle -> frogY=416, frogX=320 (up wins). Hold hop_up 10 cycles -> exactly 3 hops (cycles 0, 4, 8); frogY=352.
- Frog at (320,160), log at (300,160) -> on_log=1 one cycle later. Then 5 log_moved pulses -> frogX=325. Hop_right coincident with a pulse -> frogX += 32 only.
- Frog at (320,160), log at (400,160), |dx|=80 -> died pulse, lives=2, dead=1 for 8 cycles, then frogX=320, frogY=448, state LAND.
- Riding frog at frogX=431 with one log_moved pulse -> died=1 and frogX stays 431.
- Three deaths -> lives=0, game_over=1 and held; all hops ignored until Reset.
- With FROG_HOP_LATCH_EN, a hop_right pulse during cooldown -> executed at cooldown 0. Without the macro -> ignored.
